// File: rtl/operand_fetch_if.sv
// operand_fetch_if: instruction, ALU operand and writeback bundle around operand_fetch
// slave: the issue stage. It takes in the instruction, alu_ready and writeback,
//        and drives instruction_ready, the ALU operand set and illegal_instruction.
// master: the surrounding fetch, ALU and writeback logic.
interface operand_fetch_if;
  logic        instruction_valid;
  logic [31:0] instruction;
  logic        instruction_ready;
  logic        alu_valid;
  logic        alu_ready;
  logic [2:0]  funct3;
  logic [31:0] register_data_1;
  logic [31:0] register_data_2;
  logic [4:0]  alu_rd;
  logic        writeback_enable;
  logic [4:0]  writeback_address;
  logic [31:0] writeback_data;
  logic        illegal_instruction;
  modport slave (
    input  instruction_valid, instruction, alu_ready,
    input  writeback_enable, writeback_address, writeback_data,
    output instruction_ready, alu_valid, funct3, register_data_1, register_data_2, alu_rd,
    output illegal_instruction
  );
  modport master (
    output instruction_valid, instruction, alu_ready,
    output writeback_enable, writeback_address, writeback_data,
    input  instruction_ready, alu_valid, funct3, register_data_1, register_data_2, alu_rd,
    input  illegal_instruction
  );
endinterface

// File: rtl/operand_fetch.sv
// operand_fetch: RV32I OP/OP-IMM issue stage with register file, busy scoreboard and registered ALU operand stage
// clock   : rising-edge clock
// reset_n : asynchronous active-low reset
// bus     : operand_fetch_if.slave. It carries the instruction handshake, the
//           registered ALU operand set with valid/ready, the writeback port and
//           the illegal_instruction pulse.
module operand_fetch (
  input logic clock,
  input logic reset_n,
  operand_fetch_if.slave bus
);
  logic [6:0]  opcode, funct7;
  logic [4:0]  rs1, rs2, rd;
  logic [2:0]  f3;
  logic        is_op, is_imm, is_shift, legal, hazard, accept;
  logic [31:0] busy, wb_mask, live_busy, rs1_value, rs2_value, operand_2;
  logic [31:0] rf [32];
  always_comb begin
    opcode = bus.instruction[6:0];
    rd = bus.instruction[11:7];
    f3 = bus.instruction[14:12];
    rs1 = bus.instruction[19:15];
    rs2 = bus.instruction[24:20];
    funct7 = bus.instruction[31:25];
    is_op = opcode == 7'b0110011;
    is_imm = opcode == 7'b0010011;
    is_shift = f3 == 3'd1 || f3 == 3'd5;
    legal = is_op ? funct7 == '0 : is_imm && (!is_shift || funct7 == '0);
    // a register being written back this cycle no longer blocks issue
    wb_mask = bus.writeback_enable ? 32'd1 << bus.writeback_address : '0;
    live_busy = busy & ~wb_mask;
    hazard = legal && (live_busy[rs1] || live_busy[rd] || (is_op && live_busy[rs2]));
    bus.instruction_ready = (!bus.alu_valid || bus.alu_ready) && !hazard;
    accept = bus.instruction_valid && bus.instruction_ready;
    rs1_value = rs1 == '0 ? '0 :
                bus.writeback_enable && bus.writeback_address == rs1 ? bus.writeback_data : rf[rs1];
    rs2_value = rs2 == '0 ? '0 :
                bus.writeback_enable && bus.writeback_address == rs2 ? bus.writeback_data : rf[rs2];
    operand_2 = is_op ? rs2_value :
                is_shift ? {27'd0, bus.instruction[24:20]} :
                {{20{bus.instruction[31]}}, bus.instruction[31:20]};
  end
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n)
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    else if (bus.writeback_enable && bus.writeback_address != '0)
      rf[bus.writeback_address] <= bus.writeback_data;
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      busy <= '0;
      bus.alu_valid <= 1'b0;
      bus.illegal_instruction <= 1'b0;
      bus.funct3 <= '0;
      bus.register_data_1 <= '0;
      bus.register_data_2 <= '0;
      bus.alu_rd <= '0;
    end else begin
      // issue sets after the writeback clear, so a same-cycle rd match stays busy
      busy <= (live_busy | (accept && legal ? 32'd1 << rd : '0)) & ~32'd1;
      bus.illegal_instruction <= accept && !legal;
      if (accept && legal) begin
        bus.alu_valid <= 1'b1;
        bus.funct3 <= f3;
        bus.register_data_1 <= rs1_value;
        bus.register_data_2 <= operand_2;
        bus.alu_rd <= rd;
      end else if (bus.alu_ready)
        bus.alu_valid <= 1'b0;
    end
endmodule
